// File: rtl/simmem_wresp_responder.sv
// Write-response endpoint for the simulated memory controller: queues write-address
// IDs and answers each one in order after a fixed latency.

package simmem_pkg;
   localparam int unsigned IDWidth   = 6;
   localparam int unsigned AddrWidth = 32;

   typedef struct packed {
      logic [IDWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [7:0]           len;
      logic [2:0]           size;
      logic [1:0]           burst;
   } waddr_req_t;

   typedef struct packed {
      logic [IDWidth-1:0] id;
      logic [1:0]         resp;
   } wresp_t;
endpackage

module simmem_wresp_responder #(
   parameter int unsigned Capacity = 8,
   parameter int unsigned Latency  = 4
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              waddr_valid_i,
   output logic                              waddr_ready_o,
   input  simmem_pkg::waddr_req_t            waddr_data_i,
   output logic                              wresp_valid_o,
   input  logic                              wresp_ready_i,
   output simmem_pkg::wresp_t                wresp_data_o,
   output logic [$clog2(Capacity):0]         occupancy_o
);

   localparam int unsigned PtrW = $clog2(Capacity);
   localparam int unsigned OccW = PtrW + 1;
   localparam int unsigned CntW = $clog2(Latency + 1);
   localparam int unsigned IdW  = simmem_pkg::IDWidth;

   logic [IdW-1:0]  id_q  [Capacity];
   logic [CntW-1:0] cnt_q [Capacity];
   logic [PtrW-1:0] rptr_q;
   logic [PtrW-1:0] wptr_q;
   logic [OccW-1:0] occ_q;

   logic                push;
   logic                pop;
   logic [Capacity-1:0] occupied;
   logic                unused_req;

   // Only the id travels through the queue; the rest of the request is ignored.
   assign unused_req = ^{waddr_data_i.addr, waddr_data_i.len,
                         waddr_data_i.size, waddr_data_i.burst};

   // Ready looks at occupancy only, so a pop in the same cycle cannot free a slot.
   assign waddr_ready_o = (occ_q < OccW'(Capacity));
   assign wresp_valid_o = (occ_q != '0) && (cnt_q[rptr_q] == '0);
   assign occupancy_o   = occ_q;

   assign push = waddr_valid_i && waddr_ready_o;
   assign pop  = wresp_valid_o && wresp_ready_i;

   always_comb begin
      wresp_data_o = '0;
      if (wresp_valid_o) begin
         wresp_data_o.id = id_q[rptr_q];
      end
   end

   // An entry is live when its distance from the read pointer is below occupancy.
   for (genvar i = 0; i < Capacity; i++) begin : g_occupied
      assign occupied[i] = {1'b0, PtrW'(PtrW'(i) - rptr_q)} < occ_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr_q <= '0;
         wptr_q <= '0;
         occ_q  <= '0;
         for (int i = 0; i < Capacity; i++) begin
            id_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < Capacity; i++) begin
            if (push && (wptr_q == PtrW'(i))) begin
               id_q[i]  <= waddr_data_i.id;
               cnt_q[i] <= CntW'(Latency - 1);
            end else if (occupied[i] && (cnt_q[i] != '0)) begin
               cnt_q[i] <= cnt_q[i] - 1'b1;
            end
         end
         if (push) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 1'b1;
            2'b01:   occ_q <= occ_q - 1'b1;
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule

// File: tb/tb_simmem_wresp_responder.sv
// Bench for simmem_wresp_responder: per-cycle reference queue model plus a latency
// table and hand-written burst, full, wrap and reset sequences.

module tb_simmem_wresp_responder;

   localparam int CAP = 8;
   localparam int LAT = 4;
   localparam int IDW = simmem_pkg::IDWidth;

   logic                   clk;
   logic                   rst_ni;
   logic                   waddr_valid;
   logic                   waddr_ready;
   simmem_pkg::waddr_req_t waddr_data;
   logic                   wresp_valid;
   logic                   wresp_ready;
   simmem_pkg::wresp_t     wresp_data;
   logic [$clog2(CAP):0]   occupancy;

   simmem_wresp_responder #(.Capacity(CAP), .Latency(LAT)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .waddr_valid_i (waddr_valid),
      .waddr_ready_o (waddr_ready),
      .waddr_data_i  (waddr_data),
      .wresp_valid_o (wresp_valid),
      .wresp_ready_i (wresp_ready),
      .wresp_data_o  (wresp_data),
      .occupancy_o   (occupancy)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt  = 0;
   int check_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      check_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // scoreboard: ids in acceptance order and the cycle each becomes due
   logic [IDW-1:0] exp_q[$];
   int             due_q[$];
   int             pops         = 0;
   int             last_pop_cyc = 0;
   int             last_pop_id  = 0;
   int             last_push_cyc = 0;

   always @(negedge clk) begin
      logic ready_m;
      logic valid_m;
      if (!rst_ni) begin
         check("rst_occupancy", int'(occupancy), 0);
         check("rst_waddr_ready", int'(waddr_ready), 1);
         check("rst_wresp_valid", int'(wresp_valid), 0);
         check("rst_wresp_data", int'(wresp_data), 0);
         exp_q.delete();
         due_q.delete();
      end else begin
         ready_m = (exp_q.size() < CAP);
         valid_m = (exp_q.size() > 0) && (cyc >= due_q[0]);
         check("occupancy", int'(occupancy), exp_q.size());
         check("waddr_ready", int'(waddr_ready), int'(ready_m));
         check("wresp_valid", int'(wresp_valid), int'(valid_m));
         if (valid_m) begin
            check("wresp_id", int'(wresp_data.id), int'(exp_q[0]));
            check("wresp_code", int'(wresp_data.resp), 0);
         end else begin
            check("wresp_data_idle", int'(wresp_data), 0);
         end
         if (valid_m && wresp_ready) begin
            last_pop_id  = int'(wresp_data.id);
            last_pop_cyc = cyc;
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            pops++;
         end
         if (waddr_valid && ready_m) begin
            exp_q.push_back(waddr_data.id);
            due_q.push_back(cyc + LAT);
            last_push_cyc = cyc;
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Holds valid until accepted; leaves valid high so back-to-back sends stream.
   task automatic send(input logic [IDW-1:0] id);
      int   budget = 50;
      logic acc    = 1'b0;
      waddr_valid     = 1'b1;
      waddr_data.id   = id;
      waddr_data.addr = $urandom;
      waddr_data.len  = 8'($urandom_range(0, 255));
      while (!acc && budget > 0) begin
         @(negedge clk);
         acc = waddr_ready;
         @(posedge clk);
         #1;
         budget--;
      end
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic idle();
      waddr_valid = 1'b0;
      waddr_data  = '0;
      step();
   endtask

   task automatic drain();
      int budget = 200;
      while (exp_q.size() != 0 && budget > 0) begin
         step();
         budget--;
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   typedef struct {
      logic [IDW-1:0] id;
      int             low_cycles;
      int             exp_pop_lat;
   } vec_t;

   vec_t tbl[5];

   initial begin
      // {id, cycles with wresp_ready low after request, expected request-to-pop cycles}
      tbl[0] = '{id: 6'd5,  low_cycles: 0, exp_pop_lat: 4};
      tbl[1] = '{id: 6'd3,  low_cycles: 6, exp_pop_lat: 6};
      tbl[2] = '{id: 6'd0,  low_cycles: 4, exp_pop_lat: 4};
      tbl[3] = '{id: 6'd63, low_cycles: 9, exp_pop_lat: 9};
      tbl[4] = '{id: 6'd42, low_cycles: 2, exp_pop_lat: 4};

      rst_ni      = 1'b0;
      waddr_valid = 1'b0;
      waddr_data  = '0;
      wresp_ready = 1'b0;
      repeat (3) step();
      rst_ni = 1'b1;
      repeat (2) step();

      // single requests with varying backpressure
      for (int k = 0; k < 5; k++) begin
         int t0;
         int p0;
         int budget;
         p0 = pops;
         wresp_ready = (tbl[k].low_cycles == 0);
         send(tbl[k].id);
         t0 = last_push_cyc;
         waddr_valid = 1'b0;
         budget = 40;
         while (pops == p0 && budget > 0) begin
            if (cyc >= t0 + tbl[k].low_cycles) wresp_ready = 1'b1;
            step();
            budget--;
         end
         check("tbl_pop_latency", last_pop_cyc - t0, tbl[k].exp_pop_lat);
         check("tbl_pop_id", last_pop_id, int'(tbl[k].id));
         repeat (2) step();
      end

      // burst of ids 1..8 with ready high
      wresp_ready = 1'b1;
      for (int i = 1; i <= 8; i++) send(IDW'(i));
      idle();
      drain();
      repeat (2) step();

      // fill to capacity, hold a 9th request, then release backpressure
      wresp_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(IDW'(10 + i));
      waddr_data.id = 6'd9;
      repeat (3) step();
      check("full_occupancy", int'(occupancy), 8);
      check("full_ready_low", int'(waddr_ready), 0);
      wresp_ready = 1'b1;
      send(6'd9);
      idle();
      drain();
      repeat (2) step();

      // 20-request stream with wrap and simultaneous push/pop
      wresp_ready = 1'b1;
      for (int i = 0; i < 20; i++) send(IDW'($urandom_range(0, 63)));
      idle();
      drain();
      repeat (2) step();

      // asynchronous reset with three entries outstanding
      wresp_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(IDW'(30 + i));
      idle();
      repeat (3) step();
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_rst_valid", int'(wresp_valid), 0);
      check("async_rst_occupancy", int'(occupancy), 0);
      repeat (2) step();
      rst_ni      = 1'b1;
      wresp_ready = 1'b1;
      repeat (20) step();

      check("end_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
